// File: rtl/debug_select_scheduler_pkg.sv
// Shared definitions for the debug/LED select scheduler.
//   SEL_W             : width of a probe-mux select code
//   dbg_sched_state_e : scheduler FSM states
//   is_valid_sel()    : the valid select-code list, also used by the probe mux
package debug_sched_pkg;

  localparam int unsigned SEL_W = 8;

  typedef enum logic [1:0] {
    ST_MANUAL,
    ST_SEEK,
    ST_DWELL,
    ST_FAULT
  } dbg_sched_state_e;

  // Valid: 00-0B, 20-2B, 30-34, 40-4F, 50-5B, 60-6F
  function automatic logic is_valid_sel(input logic [SEL_W-1:0] sel);
    logic [3:0] lo_nib;
    lo_nib = sel[3:0];
    case (sel[7:4])
      4'h0, 4'h2, 4'h5: return (lo_nib <= 4'hB);
      4'h3:             return (lo_nib <= 4'h4);
      4'h4, 4'h6:       return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/debug_select_scheduler_if.sv
// Host select-write handshake.
//   host_sel_valid : host write request
//   host_sel_data  : requested select code
//   host_sel_ready : write accepted when high together with valid
//   host_sel_err   : one-cycle pulse when an accepted code is invalid
interface debug_select_scheduler_if;
  import debug_sched_pkg::*;

  logic             host_sel_valid;
  logic [SEL_W-1:0] host_sel_data;
  logic             host_sel_ready;
  logic             host_sel_err;

  modport master (
    output host_sel_valid, host_sel_data,
    input  host_sel_ready, host_sel_err
  );

  modport slave (
    input  host_sel_valid, host_sel_data,
    output host_sel_ready, host_sel_err
  );

endinterface

// File: rtl/debug_select_scheduler_dwell_timer.sv
// Dwell timer: counts while enabled, clear has priority.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart count from zero
//   en         : count this cycle
//   limit      : dwell length in cycles (0 behaves as 1)
//   done       : high while the count sits on the last cycle of the dwell
module debug_dwell_timer #(
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               en,
  input  logic [DWELL_W-1:0] limit,
  output logic               done
);

  logic [DWELL_W-1:0] count;
  logic [DWELL_W-1:0] last;

  always_comb begin
    last = (limit == '0) ? '0 : limit - DWELL_W'(1);
    done = (count == last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/debug_select_scheduler.sv
// Sequencer for the 8-bit probe-mux select code (20 MHz domain).
// Sources in priority order: latched fault override, host writes, range scan.
//   clk_20mhz, rst_n_20mhz : clock, asynchronous active-low reset
//   host                   : host write handshake (slave side)
//   scan_en                : rising edge starts a scan of [scan_lo, scan_hi]
//   dwell_cycles           : hold time per scanned code (0 behaves as 1)
//   fault_req / fault_clr  : enter / leave the fault override with fault_sel
//   state_led_ctr          : registered select code
//   sel_changed            : pulse when state_led_ctr takes a new value
//   scan_active            : in SEEK or DWELL
//   fault_active           : in FAULT
//   scan_err               : pulse when a scan finds no valid code
module debug_select_scheduler import debug_sched_pkg::*; #(
  parameter int unsigned      DWELL_W     = 24,
  parameter logic [SEL_W-1:0] DEFAULT_SEL = 8'h00
) (
  input  logic                 clk_20mhz,
  input  logic                 rst_n_20mhz,
  debug_select_scheduler_if.slave host,
  input  logic                 scan_en,
  input  logic [SEL_W-1:0]     scan_lo,
  input  logic [SEL_W-1:0]     scan_hi,
  input  logic [DWELL_W-1:0]   dwell_cycles,
  input  logic                 fault_req,
  input  logic [SEL_W-1:0]     fault_sel,
  input  logic                 fault_clr,
  output logic [SEL_W-1:0]     state_led_ctr,
  output logic                 sel_changed,
  output logic                 scan_active,
  output logic                 fault_active,
  output logic                 scan_err
);

  dbg_sched_state_e state, state_nxt;
  logic [SEL_W-1:0] sel_nxt, cand, cand_nxt, cand_inc, saved_sel, saved_sel_nxt;
  logic [8:0]       step, step_nxt, step_inc;
  logic             ret_scan, ret_scan_nxt;
  logic             scan_en_q, scan_rise;
  logic             host_ready, host_hs;
  logic             herr_nxt, serr_nxt;
  logic             timer_clear, timer_en, dwell_done;

  assign host_ready          = (state != ST_FAULT) && !fault_req;
  assign host.host_sel_ready = host_ready;
  assign host_hs             = host.host_sel_valid && host_ready;
  assign scan_rise           = scan_en && !scan_en_q;

  debug_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk   (clk_20mhz),
    .rst_n (rst_n_20mhz),
    .clear (timer_clear),
    .en    (timer_en),
    .limit (dwell_cycles),
    .done  (dwell_done)
  );

  always_comb begin
    state_nxt     = state;
    sel_nxt       = state_led_ctr;
    cand_nxt      = cand;
    step_nxt      = step;
    saved_sel_nxt = saved_sel;
    ret_scan_nxt  = ret_scan;
    herr_nxt      = 1'b0;
    serr_nxt      = 1'b0;
    timer_clear   = 1'b0;
    timer_en      = (state == ST_DWELL);
    cand_inc      = cand + 8'd1;
    step_inc      = step + 9'd1;

    if (state == ST_FAULT) begin
      // Clear beats a simultaneous request; repeated requests are ignored.
      if (fault_clr) begin
        sel_nxt = saved_sel;
        if (ret_scan) begin
          state_nxt   = ST_DWELL;
          timer_clear = 1'b1;
        end else begin
          state_nxt = ST_MANUAL;
        end
      end
    end else if (fault_req) begin
      saved_sel_nxt = state_led_ctr;
      ret_scan_nxt  = (state != ST_MANUAL);
      sel_nxt       = fault_sel;
      state_nxt     = ST_FAULT;
    end else if (host_hs) begin
      // Host writes pre-empt any scan activity.
      state_nxt = ST_MANUAL;
      if (is_valid_sel(host.host_sel_data)) begin
        sel_nxt = host.host_sel_data;
      end else begin
        herr_nxt = 1'b1;
      end
    end else begin
      case (state)
        ST_MANUAL: begin
          if (scan_rise) begin
            cand_nxt  = scan_lo;
            step_nxt  = '0;
            state_nxt = ST_SEEK;
          end
        end
        ST_SEEK: begin
          if (scan_lo > scan_hi) begin
            serr_nxt  = 1'b1;
            state_nxt = ST_MANUAL;
          end else if (is_valid_sel(cand) && (cand >= scan_lo) && (cand <= scan_hi)) begin
            sel_nxt     = cand;
            timer_clear = 1'b1;
            state_nxt   = ST_DWELL;
          end else if (step_inc == 9'd256) begin
            serr_nxt  = 1'b1;
            state_nxt = ST_MANUAL;
          end else begin
            step_nxt = step_inc;
            cand_nxt = ((cand == 8'hFF) || (cand_inc > scan_hi)) ? scan_lo : cand_inc;
          end
        end
        ST_DWELL: begin
          if (!scan_en) begin
            state_nxt = ST_MANUAL;
          end else if (dwell_done) begin
            cand_nxt  = state_led_ctr + 8'd1;
            step_nxt  = '0;
            state_nxt = ST_SEEK;
          end
        end
        default: state_nxt = ST_MANUAL;
      endcase
    end
  end

  always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
    if (!rst_n_20mhz) begin
      state             <= ST_MANUAL;
      state_led_ctr     <= DEFAULT_SEL;
      cand              <= '0;
      step              <= '0;
      saved_sel         <= DEFAULT_SEL;
      ret_scan          <= 1'b0;
      scan_en_q         <= 1'b0;
      sel_changed       <= 1'b0;
      host.host_sel_err <= 1'b0;
      scan_err          <= 1'b0;
      scan_active       <= 1'b0;
      fault_active      <= 1'b0;
    end else begin
      state             <= state_nxt;
      state_led_ctr     <= sel_nxt;
      cand              <= cand_nxt;
      step              <= step_nxt;
      saved_sel         <= saved_sel_nxt;
      ret_scan          <= ret_scan_nxt;
      scan_en_q         <= scan_en;
      sel_changed       <= (sel_nxt != state_led_ctr);
      host.host_sel_err <= herr_nxt;
      scan_err          <= serr_nxt;
      scan_active       <= (state_nxt == ST_SEEK) || (state_nxt == ST_DWELL);
      fault_active      <= (state_nxt == ST_FAULT);
    end
  end

endmodule
